// File: rtl/scan_shr_pkg.sv
// Shared constants for the display scan shifter: mode encodings and the one-cold reset pattern.
// Combinational helpers only; no latency; no flow control.
// Optional build macro handled elsewhere: SCAN_SHR_ONECOLD_CHECK_EN.
package calc_shr_pkg;

    localparam int MODE_W    = 3;
    localparam int MAX_WIDTH = 16;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd5;

    // All ones except bit 0: digit 0 is the active (low) anode after reset.
    function automatic logic [MAX_WIDTH-1:0] default_pattern(input int width);
        logic [MAX_WIDTH-1:0] p;
        p = '0;
        for (int i = 1; i < MAX_WIDTH; i++) begin
            if (i < width) p[i] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/scan_shr_if.sv
// Control and status bundle between the display timing logic and the scan shifter.
// No latency of its own; no backpressure, the shifter accepts every cycle.
// The optional onecold_err output (SCAN_SHR_ONECOLD_CHECK_EN) is a plain port on scan_shr.
interface scan_shr_if
    import calc_shr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic              enable;
    logic [MODE_W-1:0] mode;
    logic              si;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  out;
    logic              so;
    logic [IDX_W-1:0]  idx;
    logic              idx_valid;
    logic              tick;
    logic              wrap;

    modport master (
        output enable, mode, si, load_val,
        input  out, so, idx, idx_valid, tick, wrap
    );

    modport slave (
        input  enable, mode, si, load_val,
        output out, so, idx, idx_valid, tick, wrap
    );
endinterface

// File: rtl/scan_shr_prescaler.sv
// Scan prescaler: raises step on every PRESCALE-th running cycle, tick is step delayed one cycle.
// step is combinational from cnt and run; tick has one cycle of latency.
// No backpressure: run=0 freezes the count, clr restarts it.
module scan_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic step,
    output logic tick
);
    localparam int               CNT_W = $clog2(PRESCALE) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    assign step = run && (cnt_q == LAST);
    assign tick = tick_q;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            tick_d = step;
            cnt_d  = step ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end
endmodule

// File: rtl/scan_shr.sv
// Universal digit-select shifter with prescaler, active-digit index and wrap strobe.
// One-cycle latency from step/load to out; idx/idx_valid are combinational from out.
// No backpressure; optional one-cold guard on rotates via SCAN_SHR_ONECOLD_CHECK_EN.
module scan_shr
    import calc_shr_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(default_pattern(WIDTH)),
    parameter int               PRESCALE      = 1,
    parameter int               IDX_W         = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset,
    scan_shr_if.slave  bus
`ifdef SCAN_SHR_ONECOLD_CHECK_EN
    ,
    output logic       onecold_err
`endif
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             so_q, so_d;
    logic             wrap_q, wrap_d;
    logic             ld, run, step, tick;
    logic [WIDTH-1:0] zeros;
    logic             idx_valid_c;
    logic [IDX_W-1:0] idx_c;

    assign ld  = bus.enable && (bus.mode == MODE_LOAD);
    assign run = bus.enable && (bus.mode != MODE_LOAD);

    scan_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (ld),
        .step  (step),
        .tick  (tick)
    );

    // Exactly one zero <=> ~out is a nonzero power of two.
    assign zeros       = ~out_q;
    assign idx_valid_c = (zeros != '0) && ((zeros & (zeros - WIDTH'(1))) == '0);

    always_comb begin
        idx_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!out_q[i]) idx_c = IDX_W'(i);
        end
    end

`ifdef SCAN_SHR_ONECOLD_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        out_d  = out_q;
        so_d   = so_q;
        wrap_d = 1'b0;
`ifdef SCAN_SHR_ONECOLD_CHECK_EN
        err_d  = 1'b0;
`endif
        if (ld) begin
            out_d = bus.load_val;
        end else if (step) begin
            case (bus.mode)
                MODE_SHL: begin
                    out_d = {out_q[WIDTH-2:0], bus.si};
                    so_d  = out_q[WIDTH-1];
                end
                MODE_SHR: begin
                    out_d = {bus.si, out_q[WIDTH-1:1]};
                    so_d  = out_q[0];
                end
                MODE_ROL, MODE_ROR: begin
`ifdef SCAN_SHR_ONECOLD_CHECK_EN
                    if (!idx_valid_c) begin
                        out_d = RESET_PATTERN;
                        err_d = 1'b1;
                    end else
`endif
                    if (bus.mode == MODE_ROL) begin
                        out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                        so_d   = out_q[WIDTH-1];
                        wrap_d = !out_q[WIDTH-1];
                    end else begin
                        out_d  = {out_q[0], out_q[WIDTH-1:1]};
                        so_d   = out_q[0];
                        wrap_d = !out_q[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= RESET_PATTERN;
            so_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            so_q   <= so_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef SCAN_SHR_ONECOLD_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign onecold_err = err_q;
`endif

    assign bus.out       = out_q;
    assign bus.so        = so_q;
    assign bus.idx       = idx_c;
    assign bus.idx_valid = idx_valid_c;
    assign bus.tick      = tick;
    assign bus.wrap      = wrap_q;
endmodule

// File: doc/scan_shr.md
Name: scan_shr

Overview:
- Parametrised successor to the 4-bit digit-select shift register used by the calculator's 7-segment display multiplexer.
- Adds generic width and a mode-selectable universal shifter: shift left/right, rotate left/right, parallel load.
- Adds a built-in scan prescaler, plus a binary index and a wrap strobe so the digit mux can follow the active digit without extra logic.
- Sits between the display timing logic and the anode drivers / digit-data mux.

Parameters:
- WIDTH, 4, register width (number of digits); legal range 2..16.
- RESET_PATTERN, {WIDTH-1{1'b1}, 1'b0} (4'b1110 at default), value loaded on reset.
- PRESCALE, 1, number of enabled cycles per shift/rotate step; legal range 1..65535.
- IDX_W, $clog2(WIDTH), width of the idx output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global advance qualifier.
- mode  in  3  operation select: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD; 6 and 7 act as HOLD.
- si  in  1  serial input for SHL/SHR.
- load_val  in  WIDTH  parallel load value.
- out  out  WIDTH  register contents.
- so  out  1  last bit shifted or rotated out.
- idx  out  IDX_W  index of the lowest-numbered 0 bit of out; 0 if none.
- idx_valid  out  1  high when out has exactly one 0 bit.
- tick  out  1  one-cycle prescaler strobe.
- wrap  out  1  one-cycle pulse when a rotate carries the 0 bit across the end of the register.

Behaviour:
- Reset (reset==0 at a clk edge) has priority over everything. Resulting state:
  - out=RESET_PATTERN, so=0, tick=0, wrap=0, prescale counter=0.
  - At the default pattern this gives idx=0, idx_valid=1.
- Prescaler (counter cnt, width clog2(PRESCALE)+1):
  - Counts only when enable=1 and mode!=LOAD.
  - A step occurs on an enabled cycle with cnt==PRESCALE-1. On that cycle cnt wraps to 0 and tick is registered high for the next cycle.
  - enable=0 freezes cnt; tick and wrap drop to 0.
  - PRESCALE=1 gives a step on every enabled cycle.
  - In HOLD, cnt and tick still run, but out is unchanged.
- Operations on a step (next-cycle register values, 1-cycle latency):
  - SHL: out={out[W-2:0],si}, so=out[W-1].
  - SHR: out={si,out[W-1:1]}, so=out[0].
  - ROL: out={out[W-2:0],out[W-1]}, so=out[W-1].
  - ROR: out={out[0],out[W-1:1]}, so=out[0].
- LOAD:
  - Acts on any cycle with enable=1, with no prescaler dependency.
  - Sets out=load_val, cnt=0, tick=0.
  - so is unchanged.
- wrap:
  - Registered high for one cycle on a ROL step with out[W-1]==0, or a ROR step with out[0]==0.
  - wrap and tick assert on the same cycle when both apply.
- idx and idx_valid are combinational from the registered out (no added latency).
  - All-ones out: idx=0, idx_valid=0.
  - Multiple zeros: idx = lowest zero position, idx_valid=0.
- so holds its value through HOLD and non-step cycles.
- Reset asserted mid-prescale discards the partial count.
- Mode changes take effect on the cycle they are sampled. cnt is not cleared on a mode change, except on entry to LOAD.

Optional Feature:
- Macro SCAN_SHR_ONECOLD_CHECK_EN.
- When defined:
  - On a ROL/ROR step with idx_valid==0, out is reloaded with RESET_PATTERN instead of rotating; so is unchanged and wrap=0.
  - Extra output port onecold_err (1 bit) pulses high for the following cycle; reset value 0.
- When undefined:
  - Rotates proceed on any pattern.
  - The port does not exist.

Decomposition:
- Package calc_shr_pkg holds:
  - mode encodings as localparams MODE_HOLD..MODE_LOAD (3-bit);
  - the MODE_W=3 constant;
  - a function default_pattern(width) returning the one-cold-low pattern.
- Sub-module scan_prescaler (parameter PRESCALE; ports clk, reset, run, clr, step, tick) owns cnt and tick.
- scan_shr instantiates scan_prescaler once and holds the datapath, so, wrap and the index encoder.

Test Plan:
- Reset/rotate:
  - Stimulus: defaults, reset low 2 cycles, then enable=1, mode=ROL for 5 cycles.
  - Required: out after reset 1110 (idx=0, idx_valid=1), then 1101, 1011, 0111, 1110, 1101.
  - Required: wrap pulses on the cycle out returns to 1110; idx reads 0,1,2,3,0,1.
- Prescaled rotate:
  - Stimulus: PRESCALE=3, mode=ROR, enable held 1.
  - Required: out 1110 -> 0111 after 3 cycles, then -> 1011 after 3 more; tick high exactly every 3rd cycle.
- Enable gating:
  - Stimulus: PRESCALE=3, mode=ROL, enable pulsed 1,0,1,0,1.
  - Required: a single step after the third enabled cycle; out constant while enable=0.
- Shift and serial out:
  - Stimulus: WIDTH=8, LOAD load_val=8'hA5, then SHR with si=1 twice.
  - Required: out A5 -> D2 -> E9; so=1 then 0.
- Load/reset priority:
  - Stimulus: LOAD 4'b0011 with PRESCALE=4 mid-count, then ROL.
  - Required: cnt restarts, first step 4 cycles after the load gives out 0110, idx_valid=0 throughout.
  - Stimulus: assert reset on the same cycle as a step.
  - Required: out=1110, step discarded.
- SCAN_SHR_ONECOLD_CHECK_EN:
  - Stimulus: LOAD 4'b1001, then ROL step.
  - Required: out=1110, onecold_err pulses 1 cycle, wrap=0.
  - Required without the macro: out=0011.
